// File: rtl/mat_result_drain.sv
// Result-side drain for the systolic array: deskews lanes, buffers aligned rows in a row FIFO and
// serialises them onto an element stream. Optional drop counter: MAT_RESULT_DRAIN_DROP_COUNT_EN.
module mat_result_drain #(
  parameter int unsigned N          = 4,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   IN_VALID,
  input  logic [N*DATA_WIDTH-1:0]                DATA_IN,
  output logic                                   OUT_VALID,
  input  logic                                   OUT_READY,
  output logic [DATA_WIDTH-1:0]                  OUT_DATA,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   OUT_COL,
  output logic                                   OUT_LAST,
`ifdef MAT_RESULT_DRAIN_DROP_COUNT_EN
  output logic [7:0]                             DROP_COUNT,
`endif
  output logic                                   OVERFLOW
);

  localparam int unsigned ColW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned RowW    = N * DATA_WIDTH;
  localparam logic [ColW-1:0] LastCol = ColW'(N - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [RowW-1:0] aligned_row;
  logic            row_valid;

  // Lane i arrives i cycles late, so it is held N-1-i cycles to line up with lane N-1.
  for (genvar i = 0; i < int'(N); i++) begin : g_lane
    localparam int Dly = int'(N) - 1 - i;
    if (Dly == 0) begin : g_pass
      assign aligned_row[i*DATA_WIDTH +: DATA_WIDTH] = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sr_q [Dly];
      logic [DATA_WIDTH-1:0] sr_d [Dly];

      always_comb begin
        sr_d[0] = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 1; k < Dly; k++) begin
          sr_d[k] = sr_q[k-1];
        end
      end

      always_ff @(posedge CLK) begin
        if (!RESET) begin
          for (int k = 0; k < Dly; k++) begin
            sr_q[k] <= '0;
          end
        end else begin
          sr_q <= sr_d;
        end
      end

      assign aligned_row[i*DATA_WIDTH +: DATA_WIDTH] = sr_q[Dly-1];
    end
  end

  if (N > 1) begin : g_vpipe
    logic [N-2:0] vpipe_q, vpipe_d;

    always_comb begin
      vpipe_d    = vpipe_q << 1;
      vpipe_d[0] = IN_VALID;
    end

    always_ff @(posedge CLK) begin
      if (!RESET) begin
        vpipe_q <= '0;
      end else begin
        vpipe_q <= vpipe_d;
      end
    end

    assign row_valid = vpipe_q[N-2];
  end else begin : g_vpass
    assign row_valid = IN_VALID;
  end

  // Row FIFO
  logic [RowW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            fifo_empty, fifo_full;
  logic            push, pop, drop;
  logic [RowW-1:0] head_row;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FullCnt);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the row.
  assign push       = row_valid && (!fifo_full || pop);
  assign drop       = row_valid && fifo_full && !pop;
  assign head_row   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && push) begin
      mem_q[wr_ptr_q] <= aligned_row;
    end
  end

  // Serialiser
  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_buf_q, row_buf_d;
  logic            handshake;

  assign handshake = (state_q == StSend) && OUT_READY;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= StIdle;
      col_q     <= '0;
      row_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_buf_q <= row_buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_buf_d = row_buf_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          row_buf_d = head_row;
          col_d     = '0;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (handshake) begin
          if (col_q != LastCol) begin
            col_d = col_q + ColW'(1);
          end else if (!fifo_empty) begin
            // Chain straight into the next row without an idle bubble.
            pop       = 1'b1;
            row_buf_d = head_row;
            col_d     = '0;
          end else begin
            col_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    OUT_VALID = 1'b0;
    OUT_DATA  = '0;
    OUT_COL   = '0;
    OUT_LAST  = 1'b0;
    if (state_q == StSend) begin
      OUT_VALID = 1'b1;
      OUT_DATA  = row_buf_q[int'(col_q) * DATA_WIDTH +: DATA_WIDTH];
      OUT_COL   = col_q;
      OUT_LAST  = (col_q == LastCol);
    end
  end

`ifdef MAT_RESULT_DRAIN_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DROP_COUNT = drop_cnt_q;
  assign OVERFLOW   = (drop_cnt_q != 8'h00);
`else
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign OVERFLOW = overflow_q;
`endif

endmodule
